uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 65535, meaning the maximum number of cycles spent in WAIT before an abort (1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-004 The block SHALL have port nReset, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: requester i has a byte pending.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*8 bits: requester i byte in bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: one-cycle accept pulse to requester i.
REQ-008 The block SHALL have port tx_data, output, 8 bits: byte to the transmitter.
REQ-009 The block SHALL have port tx_valid, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-010 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse from the transmitter when the frame ends.
REQ-011 The block SHALL have port busy, output, 1 bit: high in LOAD and WAIT.
REQ-012 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the last granted requester.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set on abort.
REQ-014 The block SHALL have port err_clr, input, 1 bit: clears timeout_err.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and WAIT.
REQ-016 In IDLE with any req_valid bit high, the block SHALL select a winner, pulse req_ready[winner] for that cycle, capture its byte into tx_data, update grant_id, and go to LOAD.
REQ-017 In IDLE with no req_valid bit high, the block SHALL stay in IDLE with req_ready all zero.
REQ-018 In LOAD, the block SHALL pulse tx_valid for exactly one cycle, clear the watchdog counter, and go to WAIT.
REQ-019 In WAIT, the block SHALL return to IDLE on tx_done; the next grant can occur in that IDLE cycle, so the minimum byte-to-byte spacing is 3 cycles plus the frame time.
REQ-020 tx_done seen in IDLE or LOAD SHALL be ignored.
REQ-021 tx_data SHALL stay stable from capture until the next capture.
REQ-022 In WAIT, the watchdog SHALL increment by 1 per cycle with saturating arithmetic.
REQ-023 When the watchdog reaches TIMEOUT without tx_done, the block SHALL set timeout_err and go to IDLE.
REQ-024 If tx_done arrives in the same cycle the watchdog reaches TIMEOUT, tx_done SHALL win and timeout_err SHALL not be set.
REQ-025 Round-robin arbitration SHALL search from grant_id+1 upward, wrapping modulo NUM_REQ, and the first requester with req_valid high SHALL win.
REQ-026 Requester bits that drop before their grant SHALL simply be skipped; no grant is held and no data is buffered.
REQ-027 If err_clr and a timeout abort occur in the same cycle, set SHALL win over clear.
REQ-028 The block SHALL hold no more than one byte at a time.

Reset
REQ-029 While nReset is low, the block SHALL force state IDLE, tx_valid 0, req_ready 0, tx_data 0x00, busy 0, timeout_err 0, watchdog 0, and grant_id NUM_REQ-1, so requester 0 wins first.
REQ-030 Reset asserted mid-frame (in LOAD or WAIT) SHALL abandon the captured byte with no further tx_valid, and a tx_done after reset SHALL be ignored.

Configuration
REQ-031 The macro UART_TX_ARB_HIPRI_EN SHALL select the arbitration mode.
REQ-032 With UART_TX_ARB_HIPRI_EN defined, requester 0 SHALL win whenever req_valid[0] is high, and the remaining requesters SHALL be round-robin among themselves; grant_id SHALL still record the last winner.
REQ-033 With UART_TX_ARB_HIPRI_EN undefined, all requesters SHALL be pure round-robin as in REQ-025.

Verification
REQ-034 After reset, assert req_valid=4'b1111 with bytes 0xA0..0xA3 and respond to each tx_valid with tx_done 10 cycles later -> tx_data order SHALL be A0, A1, A2, A3, A0, and exactly one req_ready pulse SHALL occur per byte.
REQ-035 With only req_valid[2] high carrying 0x5C -> req_ready[2] SHALL pulse in the first IDLE cycle, tx_valid SHALL pulse one cycle later, and busy SHALL stay high until the cycle after tx_done.
REQ-036 With TIMEOUT=8 and tx_done never driven -> timeout_err SHALL set 8 cycles into WAIT, the FSM SHALL return to IDLE, and err_clr SHALL clear it.
REQ-037 With TIMEOUT=8, drive tx_done in the same cycle the watchdog reaches 8 -> timeout_err SHALL stay 0.
REQ-038 Assert nReset low during WAIT, then drive tx_done -> no tx_valid SHALL occur and grant_id SHALL read NUM_REQ-1.
REQ-039 With UART_TX_ARB_HIPRI_EN defined and req_valid[0] and req_valid[3] continuously high -> only requester 0 SHALL be served; without the macro, the bytes SHALL alternate 0, 3, 0, 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: picks one pending byte at a time and hands it to a UART transmitter.
// Define UART_TX_ARB_HIPRI_EN to give requester 0 absolute priority; the rest stay round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int IdW = $clog2(NUM_REQ);
  localparam int CandW = IdW + 1;
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT);
  localparam logic [IdW-1:0] LastId = IdW'(NUM_REQ - 1);
  localparam logic [CandW-1:0] NumReqC = CandW'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} stateT;

  stateT          state;
  logic [15:0]    watchdog;
  logic [15:0]    watchdogNext;
  logic [7:0]     reqByte [NUM_REQ];
  logic           anyValid;
  logic [IdW-1:0] winner;
  logic [CandW-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign reqByte[gi] = req_data[gi*8 +: 8];
    end
  endgenerate

  assign anyValid = |req_valid;

  // Walk the search order backwards so the nearest requester after grant_id is written last.
  always_comb begin
    winner = grant_id;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, grant_id} + CandW'(k);
      if (cand >= NumReqC) begin
        cand = cand - NumReqC;
      end
      if (req_valid[cand[IdW-1:0]]) begin
        winner = cand[IdW-1:0];
      end
    end
`ifdef UART_TX_ARB_HIPRI_EN
    if (req_valid[0]) begin
      winner = '0;
    end
`endif
  end

  // Ready is the same-cycle accept of the handshake, so it cannot be registered.
  always_comb begin
    req_ready = '0;
    if (nReset && state == IDLE && anyValid) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign watchdogNext = (watchdog == 16'hFFFF) ? watchdog : watchdog + 16'd1;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      watchdog    <= 16'd0;
      grant_id    <= LastId;
    end else begin
      tx_valid <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (anyValid) begin
            tx_data  <= reqByte[winner];
            grant_id <= winner;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          watchdog <= 16'd0;
          state    <= WAIT;
        end
        WAIT: begin
          watchdog <= watchdogNext;
          // A completion in the same cycle as the limit counts as success.
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (watchdogNext >= TimeoutLimit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; inputs change 1ns after posedge, outputs sampled at negedge.
// dutA uses the default watchdog, dutT a short one (8) for the abort cases.
module tb_uart_tx_arbiter;

  localparam int NumReq = 4;

  logic clk = 1'b0;
  logic nReset;
  logic [NumReq-1:0]   req_valid;
  logic [NumReq*8-1:0] req_data;
  logic tx_done;
  logic err_clr;

  logic [NumReq-1:0] readyA, readyT;
  logic [7:0]        txDataA, txDataT;
  logic              txValidA, txValidT;
  logic              busyA, busyT;
  logic [1:0]        grantA, grantT;
  logic              errA, errT;

  uart_tx_arbiter #(.NUM_REQ(NumReq)) dutA (
    .clk(clk), .nReset(nReset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(readyA), .tx_data(txDataA), .tx_valid(txValidA), .tx_done(tx_done),
    .busy(busyA), .grant_id(grantA), .timeout_err(errA), .err_clr(err_clr)
  );

  uart_tx_arbiter #(.NUM_REQ(NumReq), .TIMEOUT(8)) dutT (
    .clk(clk), .nReset(nReset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(readyT), .tx_data(txDataT), .tx_valid(txValidT), .tx_done(tx_done),
    .busy(busyT), .grant_id(grantT), .timeout_err(errT), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int readyCount = 0;
  int txCount = 0;
  logic [7:0] expQ [$];

  logic [NumReq-1:0] sReady, sReadyT;
  logic [7:0] sTxData, sTxDataT;
  logic sTxValid, sTxValidT, sBusy, sBusyT, sErr, sErrT;
  logic [1:0] sGrant, sGrantT;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    testsRun++;
    if (got !== expVal) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expVal);
    end
  endtask

  // Sample the current cycle at negedge, then move to the drive point of the next cycle.
  task automatic step();
    @(negedge clk);
    sReady = readyA;     sReadyT = readyT;
    sTxData = txDataA;   sTxDataT = txDataT;
    sTxValid = txValidA; sTxValidT = txValidT;
    sBusy = busyA;       sBusyT = busyT;
    sErr = errA;         sErrT = errT;
    sGrant = grantA;     sGrantT = grantT;
    if (|readyA) readyCount++;
    if (txValidA) txCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    nReset = 1'b0;
    req_valid = '0;
    tx_done = 1'b0;
    err_clr = 1'b0;
    repeat (2) step();
    nReset = 1'b1;
  endtask

  task automatic waitTx(input bit onT, output bit seen);
    int waited;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 200) begin
      step();
      waited++;
      seen = onT ? sTxValidT : sTxValid;
    end
    if (!seen) checkVal("txValidWait", 32'(seen), 1);
  endtask

  task automatic scoreTx();
    logic [7:0] expByte;
    checkVal("sbHasEntry", 32'(expQ.size() > 0), 1);
    if (expQ.size() > 0) begin
      expByte = expQ.pop_front();
      checkVal("txByte", 32'(sTxData), 32'(expByte));
      $display("[TB] tx byte 0x%02h from requester %0d (expected 0x%02h)", sTxData, sGrant, expByte);
    end
  endtask

  // Called at the drive point of the cycle after tx_valid; tx_done lands doneDelay cycles after it.
  task automatic finishFrame(input int doneDelay);
    repeat (doneDelay - 1) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic serve(input int n, input int doneDelay, input bit dropLast);
    bit seen;
    for (int i = 0; i < n; i++) begin
      waitTx(1'b0, seen);
      if (!seen) return;
      scoreTx();
      if (dropLast && i == n - 1) req_valid = '0;
      finishFrame(doneDelay);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL globalTimeout: time %0t, limit 400000", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    bit seen;
    int rc0;
    int tc0;
    logic [7:0] order1 [5];
    logic [7:0] order6 [4];
    logic [7:0] skipSecond;
    logic [1:0] skipGrant;
`ifdef UART_TX_ARB_HIPRI_EN
    order1 = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
    order6 = '{8'h30, 8'h30, 8'h30, 8'h30};
    skipSecond = 8'h40;
    skipGrant = 2'd0;
`else
    order1 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    order6 = '{8'h30, 8'h33, 8'h30, 8'h33};
    skipSecond = 8'h42;
    skipGrant = 2'd2;
`endif

    nReset = 1'b0;
    req_valid = '0;
    req_data = '0;
    tx_done = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, with every requester pending while reset is held
    req_valid = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (3) step();
    checkVal("rstTxValid", 32'(sTxValid), 0);
    checkVal("rstReady", 32'(sReady), 0);
    checkVal("rstTxData", 32'(sTxData), 0);
    checkVal("rstBusy", 32'(sBusy), 0);
    checkVal("rstErr", 32'(sErr), 0);
    checkVal("rstGrant", 32'(sGrant), 3);
    checkVal("rstGrantT", 32'(sGrantT), 3);
    checkVal("rstReadyT", 32'(sReadyT), 0);

    // All four pending: rotation order and one accept per byte
    nReset = 1'b1;
    foreach (order1[i]) expQ.push_back(order1[i]);
    rc0 = readyCount;
    serve(5, 10, 1'b1);
    repeat (2) step();
    checkVal("readyPulses", 32'(readyCount - rc0), 5);

    // Single requester 2: ready, then tx_valid, busy until the cycle after tx_done
    doReset();
    req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
    req_valid = 4'b0100;
    expQ.push_back(8'h5C);
    step();
    checkVal("oneReady", 32'(sReady), 32'h4);
    checkVal("oneNoTxYet", 32'(sTxValid), 0);
    checkVal("oneBusyIdle", 32'(sBusy), 0);
    step();
    scoreTx();
    checkVal("oneTxValid", 32'(sTxValid), 1);
    checkVal("oneBusyLoad", 32'(sBusy), 1);
    checkVal("oneReadyLow", 32'(sReady), 0);
    checkVal("oneGrant", 32'(sGrant), 2);
    req_valid = '0;
    step();
    checkVal("oneTxPulse", 32'(sTxValid), 0);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checkVal("oneBusyDone", 32'(sBusy), 1);
    step();
    checkVal("oneBusyAfter", 32'(sBusy), 0);

    // A requester that drops before its turn is skipped
    doReset();
    req_data = {8'h43, 8'h42, 8'h41, 8'h40};
    req_valid = 4'b0011;
    expQ.push_back(8'h40);
    waitTx(1'b0, seen);
    if (seen) scoreTx();
    req_valid = 4'b0101;
    expQ.push_back(skipSecond);
    finishFrame(4);
    waitTx(1'b0, seen);
    if (seen) scoreTx();
    req_valid = '0;
    finishFrame(4);
    step();
    checkVal("skipGrant", 32'(sGrant), 32'(skipGrant));

    // Watchdog abort on the short-timeout instance, then clear
    doReset();
    req_data = {8'h00, 8'h00, 8'h00, 8'h11};
    req_valid = 4'b0001;
    waitTx(1'b1, seen);
    checkVal("toTxData", 32'(sTxDataT), 32'h11);
    req_valid = '0;
    repeat (7) step();
    checkVal("toBusyWait", 32'(sBusyT), 1);
    step();
    checkVal("toErrAt8", 32'(sErrT), 0);
    step();
    checkVal("toErrSet", 32'(sErrT), 1);
    checkVal("toIdle", 32'(sBusyT), 0);
    err_clr = 1'b1;
    step();
    checkVal("toErrBeforeClr", 32'(sErrT), 1);
    err_clr = 1'b0;
    step();
    checkVal("toErrCleared", 32'(sErrT), 0);

    // Abort while err_clr is held: set wins that cycle
    req_valid = 4'b0001;
    err_clr = 1'b1;
    waitTx(1'b1, seen);
    req_valid = '0;
    repeat (8) step();
    step();
    checkVal("setBeatsClr", 32'(sErrT), 1);
    step();
    checkVal("clrAfterSet", 32'(sErrT), 0);
    err_clr = 1'b0;

    // tx_done in the same cycle the watchdog reaches its limit
    doReset();
    req_valid = 4'b0001;
    waitTx(1'b1, seen);
    req_valid = '0;
    repeat (7) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checkVal("raceBusy", 32'(sBusyT), 1);
    step();
    checkVal("raceNoErr", 32'(sErrT), 0);
    checkVal("raceIdle", 32'(sBusyT), 0);
    repeat (3) step();
    checkVal("raceNoErrLater", 32'(sErrT), 0);

    // Reset during WAIT drops the byte and ignores the late tx_done
    doReset();
    req_data = {8'h00, 8'h00, 8'h71, 8'h00};
    req_valid = 4'b0010;
    expQ.push_back(8'h71);
    waitTx(1'b0, seen);
    if (seen) scoreTx();
    tc0 = txCount;
    req_valid = '0;
    repeat (2) step();
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (12) step();
    checkVal("midRstNoTx", 32'(txCount - tc0), 0);
    checkVal("midRstGrant", 32'(sGrant), 3);
    checkVal("midRstBusy", 32'(sBusy), 0);

    // Requesters 0 and 3 both continuously pending
    doReset();
    req_data = {8'h33, 8'h00, 8'h00, 8'h30};
    req_valid = 4'b1001;
    foreach (order6[i]) expQ.push_back(order6[i]);
    serve(4, 3, 1'b1);
    repeat (2) step();

    checkVal("sbDrained", 32'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
